// File: rtl/pong_ball_controller.sv
// rtl/pong_ball_controller.sv - per-frame ball sequencer: motion, reflections, scoring, match state
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   frame_tick     one-clk pulse per video frame; qualifies all motion/serve updates
//   start          level; begins a match from IDLE or GAME_OVER
//   touchingPaddle bit0 = left paddle contact, bit1 = right paddle contact
//   ball_x, ball_y registered ball centre
//   score1, score2 player scores, saturating at WIN_SCORE
//   game_state     IDLE=0, SERVE=1, PLAY=2, SCORED=3, GAME_OVER=4
//   point_scored   one-clk pulse on entry to SCORED
//   game_over      high while in GAME_OVER
//
// Optional build macro: BALL_SPEEDUP_EN adds a per-rally speed register that
// grows by one on each paddle reflection, up to twice BALL_SPEED.

module pong_ball_controller #(
    parameter int BIT_WIDTH     = 10,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int BALL_RADIUS   = 4,
    parameter int BALL_SPEED    = 2,
    parameter int SERVE_DELAY   = 60,
    parameter int WIN_SCORE     = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_tick,
    input  logic                 start,
    input  logic [1:0]           touchingPaddle,
    output logic [BIT_WIDTH-1:0] ball_x,
    output logic [BIT_WIDTH-1:0] ball_y,
    output logic [3:0]           score1,
    output logic [3:0]           score2,
    output logic [2:0]           game_state,
    output logic                 point_scored,
    output logic                 game_over
);

    localparam int W1 = BIT_WIDTH + 1;
    localparam int CW = $clog2(SERVE_DELAY + 1);

    localparam logic [BIT_WIDTH-1:0] CENTRE_X = BIT_WIDTH'(SCREEN_WIDTH / 2);
    localparam logic [BIT_WIDTH-1:0] CENTRE_Y = BIT_WIDTH'(SCREEN_HEIGHT / 2);
    localparam logic [BIT_WIDTH-1:0] Y_MIN    = BIT_WIDTH'(BALL_RADIUS);
    localparam logic [BIT_WIDTH-1:0] Y_MAX    = BIT_WIDTH'(SCREEN_HEIGHT - 1 - BALL_RADIUS);
    localparam logic [W1-1:0]        LO_EDGE  = W1'(BALL_RADIUS);
    localparam logic [W1-1:0]        X_HI     = W1'(SCREEN_WIDTH - 1 - BALL_RADIUS);
    localparam logic [W1-1:0]        Y_HI     = W1'(SCREEN_HEIGHT - 1 - BALL_RADIUS);
    localparam logic [CW-1:0]        CNT_LAST = CW'(SERVE_DELAY - 1);
    localparam logic [3:0]           WIN      = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SERVE     = 3'd1,
        S_PLAY      = 3'd2,
        S_SCORED    = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    state_t               state, state_nxt;
    logic [BIT_WIDTH-1:0] x_nxt, y_nxt;
    logic                 dir_x, dir_x_nxt;   // 1 = right
    logic                 dir_y, dir_y_nxt;   // 1 = down
    logic [3:0]           score1_nxt, score2_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic                 ps_nxt;
    logic                 missed;
    logic [BIT_WIDTH-1:0] spd;
    logic [W1-1:0]        x_ext, y_ext, spd_ext;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s < WIN) ? s + 4'd1 : s;
    endfunction

`ifdef BALL_SPEEDUP_EN
    logic [BIT_WIDTH-1:0] speed, speed_nxt;
    logic                 reflect;

    assign spd = speed;

    // A reflection is exactly the case where a contact bit matches the travel direction.
    assign reflect = (state == S_PLAY) && frame_tick &&
                     ((touchingPaddle[0] && !dir_x) || (touchingPaddle[1] && dir_x));

    always_comb begin
        speed_nxt = speed;
        if (state_nxt == S_SERVE && state != S_SERVE)
            speed_nxt = BIT_WIDTH'(BALL_SPEED);
        else if (reflect && speed < BIT_WIDTH'(2 * BALL_SPEED))
            speed_nxt = speed + BIT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            speed <= BIT_WIDTH'(BALL_SPEED);
        else
            speed <= speed_nxt;
    end
`else
    assign spd = BIT_WIDTH'(BALL_SPEED);
`endif

    assign x_ext   = {1'b0, ball_x};
    assign y_ext   = {1'b0, ball_y};
    assign spd_ext = {1'b0, spd};

    always_comb begin
        state_nxt  = state;
        x_nxt      = ball_x;
        y_nxt      = ball_y;
        dir_x_nxt  = dir_x;
        dir_y_nxt  = dir_y;
        score1_nxt = score1;
        score2_nxt = score2;
        cnt_nxt    = cnt;
        ps_nxt     = 1'b0;
        missed     = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt  = S_SERVE;
                    score1_nxt = 4'd0;
                    score2_nxt = 4'd0;
                    x_nxt      = CENTRE_X;
                    y_nxt      = CENTRE_Y;
                    cnt_nxt    = '0;
                end
            end

            S_SERVE: begin
                x_nxt = CENTRE_X;
                y_nxt = CENTRE_Y;
                if (frame_tick) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = S_PLAY;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end

            S_PLAY: begin
                if (frame_tick) begin
                    // Contact only counts toward the paddle the ball is heading for,
                    // so a ball still overlapping a paddle after bouncing is not flipped back.
                    if (touchingPaddle[0] && !dir_x) begin
                        dir_x_nxt = 1'b1;
                        x_nxt     = ball_x + spd;
                    end else if (touchingPaddle[1] && dir_x) begin
                        dir_x_nxt = 1'b0;
                        x_nxt     = ball_x - spd;
                    end else if (!dir_x && x_ext < LO_EDGE + spd_ext) begin
                        score2_nxt = sat_inc(score2);
                        state_nxt  = S_SCORED;
                        ps_nxt     = 1'b1;
                        missed     = 1'b1;
                    end else if (dir_x && x_ext + spd_ext > X_HI) begin
                        score1_nxt = sat_inc(score1);
                        state_nxt  = S_SCORED;
                        ps_nxt     = 1'b1;
                        missed     = 1'b1;
                    end else begin
                        x_nxt = dir_x ? ball_x + spd : ball_x - spd;
                    end

                    // Ball freezes completely on a miss.
                    if (!missed) begin
                        if (!dir_y && y_ext < LO_EDGE + spd_ext) begin
                            y_nxt     = Y_MIN;
                            dir_y_nxt = 1'b1;
                        end else if (dir_y && y_ext + spd_ext > Y_HI) begin
                            y_nxt     = Y_MAX;
                            dir_y_nxt = 1'b0;
                        end else begin
                            y_nxt = dir_y ? ball_y + spd : ball_y - spd;
                        end
                    end
                end
            end

            S_SCORED: begin
                // dir_x still points the way the ball left the field, which is
                // toward the player who conceded, so the re-serve goes to them.
                if (frame_tick) begin
                    state_nxt = (score1 == WIN || score2 == WIN) ? S_GAME_OVER : S_SERVE;
                    x_nxt     = CENTRE_X;
                    y_nxt     = CENTRE_Y;
                    cnt_nxt   = '0;
                end
            end

            S_GAME_OVER: begin
                if (start) begin
                    state_nxt  = S_SERVE;
                    score1_nxt = 4'd0;
                    score2_nxt = 4'd0;
                    dir_x_nxt  = 1'b1;
                    x_nxt      = CENTRE_X;
                    y_nxt      = CENTRE_Y;
                    cnt_nxt    = '0;
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            ball_x       <= CENTRE_X;
            ball_y       <= CENTRE_Y;
            dir_x        <= 1'b1;
            dir_y        <= 1'b1;
            score1       <= 4'd0;
            score2       <= 4'd0;
            cnt          <= '0;
            point_scored <= 1'b0;
        end else begin
            state        <= state_nxt;
            ball_x       <= x_nxt;
            ball_y       <= y_nxt;
            dir_x        <= dir_x_nxt;
            dir_y        <= dir_y_nxt;
            score1       <= score1_nxt;
            score2       <= score2_nxt;
            cnt          <= cnt_nxt;
            point_scored <= ps_nxt;
        end
    end

    assign game_state = state;
    assign game_over  = (state == S_GAME_OVER);

endmodule
